ram_port_arbiter: RTL

//  Shares the single-port SRAM between the core's instruction-fetch port and its load/store port.

---
 rtl/ram_arb_pkg.sv | 14 +
 rtl/ram_port_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default RAM window for the fetch/data SRAM arbiter.
// The top level reuses RAM_BASE/RAM_WORDS so the wrapper and arbiter agree on the window.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_INSTR = 2'd1,
    RSP_DATA  = 2'd2
  } rsp_owner_e;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam int unsigned RAM_WORDS = 16384;

endpackage

// File: rtl/ram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store.
// Data has priority; a saturating starvation counter forces a fetch grant after StarveLimit losses.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          RamWords    = RAM_WORDS,
  parameter logic [AddrWidth-1:0] RamBase     = AddrWidth'(RAM_BASE),
  parameter int unsigned          StarveLimit = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,

  input  logic                          instr_req_i,
  input  logic [AddrWidth-1:0]          instr_addr_i,
  output logic                          instr_gnt_o,
  output logic                          instr_rvalid_o,
  output logic [DataWidth-1:0]          instr_rdata_o,
  output logic                          instr_err_o,

  input  logic                          data_req_i,
  input  logic                          data_we_i,
  input  logic [DataWidth/8-1:0]        data_be_i,
  input  logic [AddrWidth-1:0]          data_addr_i,
  input  logic [DataWidth-1:0]          data_wdata_i,
  output logic                          data_gnt_o,
  output logic                          data_rvalid_o,
  output logic [DataWidth-1:0]          data_rdata_o,
  output logic                          data_err_o,

  output logic                          ram_req_o,
  output logic                          ram_we_o,
  output logic [DataWidth/8-1:0]        ram_be_o,
  output logic [$clog2(RamWords)-1:0]   ram_addr_o,
  output logic [DataWidth-1:0]          ram_wdata_o,
  input  logic [DataWidth-1:0]          ram_rdata_i
);

  localparam int unsigned RamAw = $clog2(RamWords);
  localparam int unsigned CntW  = $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0]    StarveMax = CntW'(StarveLimit);
  // One extra bit so the window end never wraps, even for a window at the top of the map.
  localparam logic [AddrWidth:0] WinLo = {1'b0, RamBase};
  localparam logic [AddrWidth:0] WinHi = WinLo + (AddrWidth + 1)'(4 * RamWords);

  function automatic logic in_window(input logic [AddrWidth-1:0] addr);
    return ({1'b0, addr} >= WinLo) && ({1'b0, addr} < WinHi);
  endfunction

  function automatic logic [RamAw-1:0] word_index(input logic [AddrWidth-1:0] addr);
    logic [AddrWidth-1:0] offset;
    offset = addr - RamBase;
    return RamAw'(offset >> 2);
  endfunction

  logic [CntW-1:0] starve_q, starve_d;
  rsp_owner_e      rsp_owner_q;
  logic            rsp_err_q;
  logic            rsp_store_q;

  logic starved;
  logic instr_in_win, data_in_win;
  logic instr_gnt, data_gnt;

  assign starved      = (starve_q == StarveMax);
  assign instr_in_win = in_window(instr_addr_i);
  assign data_in_win  = in_window(data_addr_i);

  // Grants are gated by reset so every output sits at its reset value while rst_ni is low.
  assign instr_gnt = rst_ni & instr_req_i & (~data_req_i | starved);
  assign data_gnt  = rst_ni & data_req_i & ~instr_gnt;

  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;

  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (instr_gnt && instr_in_win) begin
      ram_req_o  = 1'b1;
      ram_be_o   = '1;
      ram_addr_o = word_index(instr_addr_i);
    end else if (data_gnt && data_in_win) begin
      ram_req_o   = 1'b1;
      ram_we_o    = data_we_i;
      ram_be_o    = data_be_i;
      ram_addr_o  = word_index(data_addr_i);
      ram_wdata_o = data_wdata_i;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!instr_req_i || instr_gnt) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Response owner is captured on grant; the RAM returns data on the following cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_owner_q <= RSP_NONE;
      rsp_err_q   <= 1'b0;
      rsp_store_q <= 1'b0;
    end else if (instr_gnt) begin
      rsp_owner_q <= RSP_INSTR;
      rsp_err_q   <= ~instr_in_win;
      rsp_store_q <= 1'b0;
    end else if (data_gnt) begin
      rsp_owner_q <= RSP_DATA;
      rsp_err_q   <= ~data_in_win;
      rsp_store_q <= data_we_i;
    end else begin
      rsp_owner_q <= RSP_NONE;
      rsp_err_q   <= 1'b0;
      rsp_store_q <= 1'b0;
    end
  end

  assign instr_rvalid_o = (rsp_owner_q == RSP_INSTR);
  assign instr_err_o    = instr_rvalid_o & rsp_err_q;
  assign instr_rdata_o  = (instr_rvalid_o && !rsp_err_q) ? ram_rdata_i : '0;

  assign data_rvalid_o = (rsp_owner_q == RSP_DATA);
  assign data_err_o    = data_rvalid_o & rsp_err_q;
  assign data_rdata_o  = (data_rvalid_o && !rsp_err_q && !rsp_store_q) ? ram_rdata_i : '0;

endmodule
